// File: rtl/pending_scoreboard.sv
// Per-register pending-write scoreboard: 2-bit counters for r1..r31 that stall
// dependent or saturating issues until the matching writebacks retire.
module pending_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       issue_valid,
  input  logic       issue_wb_en,
  input  logic [4:0] issue_dest,
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic       isSrc2,
  input  logic       wb_valid,
  input  logic [4:0] wb_dest,
  output logic       freez,
  output logic       issue_ack,
  output logic       pending_any,
  output logic       overflow_err
);

  // Entry 0 is held at zero so r0 operands read as never pending.
  logic [31:0][1:0] cnt_r;
  logic [31:0][1:0] cnt_nxt_s;
  logic             src1_busy_s;
  logic             src2_busy_s;
  logic             dest_sat_s;
  logic             inc_s;
  logic             dec_s;
  logic             underflow_s;
  logic             err_s;
  logic             pending_any_r;
  logic             overflow_err_r;

  // Hazard detection, issue handshake and error detection on current counters
  always_comb begin
    src1_busy_s = (cnt_r[src1] != 2'd0);
    src2_busy_s = isSrc2 && (cnt_r[src2] != 2'd0);
    dest_sat_s  = issue_wb_en && (issue_dest != 5'd0) && (cnt_r[issue_dest] == 2'd3);
    freez       = issue_valid && (src1_busy_s || src2_busy_s || dest_sat_s);
    issue_ack   = issue_valid && !freez && !clear;
    inc_s       = issue_ack && issue_wb_en && (issue_dest != 5'd0);
    dec_s       = wb_valid && (wb_dest != 5'd0);
    // A retire cancelled by a same-cycle issue to the same register is not an underflow.
    underflow_s = dec_s && (cnt_r[wb_dest] == 2'd0) && !(inc_s && (issue_dest == wb_dest));
    if (clear) begin
      err_s = wb_valid;
    end else begin
      err_s = underflow_s;
    end
  end

  // Next-state counters: clear wins, then matched inc/dec cancel
  always_comb begin
    cnt_nxt_s    = cnt_r;
    cnt_nxt_s[0] = 2'd0;
    for (int i = 1; i < 32; i++) begin
      if (clear) begin
        cnt_nxt_s[i] = 2'd0;
      end else if (inc_s && (issue_dest == 5'(i)) && !(dec_s && (wb_dest == 5'(i)))) begin
        cnt_nxt_s[i] = cnt_r[i] + 2'd1;
      end else if (dec_s && (wb_dest == 5'(i)) && !(inc_s && (issue_dest == 5'(i)))
                   && (cnt_r[i] != 2'd0)) begin
        cnt_nxt_s[i] = cnt_r[i] - 2'd1;
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Counter, pending and sticky-error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r          <= '0;
      pending_any_r  <= 1'b0;
      overflow_err_r <= 1'b0;
    end else begin
      cnt_r          <= cnt_nxt_s;
      pending_any_r  <= |cnt_nxt_s;
      overflow_err_r <= overflow_err_r | err_s;
    end
  end

  assign pending_any  = pending_any_r;
  assign overflow_err = overflow_err_r;

endmodule

// File: doc/pending_scoreboard.md
PENDING_SCOREBOARD -- requirements
Module: pending_scoreboard

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port list, one per line: name  direction  width  meaning:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- clear  in  1  synchronous flush of all pending entries
- issue_valid  in  1  instruction offered for issue to EXE this cycle
- issue_wb_en  in  1  offered instruction writes the register file
- issue_dest  in  5  destination register of offered instruction
- src1  in  5  first source of offered instruction
- src2  in  5  second source of offered instruction
- isSrc2  in  1  src2 is a real register operand
- wb_valid  in  1  writeback retiring this cycle
- wb_dest  in  5  register retired
- freez  out  1  stall: offered instruction must not issue
- issue_ack  out  1  offered instruction accepted this cycle
- pending_any  out  1  at least one entry non-zero (registered)
- overflow_err  out  1  sticky: retire to a zero entry, or clear/retire conflict

Function
REQ-003 The module SHALL hold one 2-bit pending counter per register, cnt[1..31]; register 0 SHALL have no counter and SHALL never be pending.
REQ-004 freez SHALL be combinational: 1 when issue_valid=1 and any of the following holds:
- cnt[src1]!=0
- isSrc2=1 and cnt[src2]!=0
- issue_wb_en=1, issue_dest!=0 and cnt[issue_dest]==3 (saturation)
REQ-005 issue_ack SHALL equal issue_valid & ~freez & ~clear.
REQ-006 The increment condition SHALL be issue_ack=1, issue_wb_en=1 and issue_dest!=0; when it holds, cnt[issue_dest] SHALL increment at the next rising edge.
REQ-007 On wb_valid=1 with wb_dest!=0, cnt[wb_dest] SHALL decrement at the next rising edge.
REQ-008 If the increment (REQ-006) and decrement (REQ-007) target the same register in one cycle, that counter SHALL be unchanged.
REQ-009 A decrement of a counter already 0 SHALL leave it at 0 and set overflow_err.
REQ-010 wb_dest=0 or issue_dest=0 SHALL affect no counter.
REQ-011 clear=1 SHALL zero all counters at the next edge, overriding any same-cycle increment or decrement.
REQ-012 clear=1 together with wb_valid=1 SHALL set overflow_err.
REQ-013 pending_any SHALL be a registered OR of next-state counters, so it matches counter contents one cycle after each update.
REQ-014 A source equal to register 0 SHALL never cause freez.
REQ-015 Issue-to-stall latency SHALL be one cycle: a dependent instruction offered in the cycle after issue SHALL see freez=1.
REQ-016 Retire-to-release latency SHALL be one cycle: in the cycle after the final wb_valid, the counter is 0 and freez drops. There is no same-cycle bypass.
REQ-017 freez SHALL be 0 whenever issue_valid=0.

Reset
REQ-018 While rst=1, and immediately on its assertion regardless of clock, all counters, pending_any and overflow_err SHALL be 0.
REQ-019 freez and issue_ack SHALL evaluate against the zeroed counters during reset.
REQ-020 An issue or writeback in flight when rst asserts SHALL be discarded.
REQ-021 overflow_err SHALL clear only on rst; clear SHALL NOT clear it.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Issue r5 (wb_en=1); next cycle offer src1=5 -> freez=1, issue_ack=0; wb_valid with wb_dest=5 -> freez=0 one cycle later, cnt[5]=0.
- Issue r7 three times with independent sources -> cnt[7]=3; a fourth issue to r7 -> freez=1; one retire of r7 -> fourth issue accepted, cnt[7]=3.
- Same-cycle issue of r9 and retire of r9 with cnt[9]=1 -> cnt[9] stays 1, pending_any=1.
- isSrc2=0, src2=4, cnt[4]=2, src1 clean -> freez=0; set isSrc2=1 -> freez=1.
- wb_valid with wb_dest=3 while cnt[3]=0 -> overflow_err=1 and held; cnt[3]=0; src1=0 with any state -> no freez.
- cnt[2]=1, cnt[6]=2, assert clear with a concurrent issue of r8 -> all counters 0, issue_ack=0, pending_any=0 next cycle; async rst mid-cycle -> outputs 0 before the next edge.
